// File: rtl/merge_pkg.sv
// Shared types and constants for the two-input stream merger.
// Source ids and the arbitration pointer reset value live here.
package merge_pkg;

    typedef logic src_t;

    localparam src_t SRC_D0 = 1'b0;
    localparam src_t SRC_D1 = 1'b1;

    // Pointer starts at d1 so the first tie after reset goes to d0.
    localparam src_t POINTER_RESET = SRC_D1;

endpackage

// File: rtl/mux2.sv
// Parameterized 2:1 multiplexer.
// Ports: d0/d1 data in, s select (1 picks d1), y data out.
module mux2 #(
    parameter int width = 8
) (
    input  logic [width-1:0] d0,
    input  logic [width-1:0] d1,
    input  logic             s,
    output logic [width-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/stream_merge2.sv
// Merges two valid/ready streams into one registered output stream.
// Ports: d0/d1 (+valid/ready) in, y/y_valid/y_src out with y_ready.
module stream_merge2
    import merge_pkg::*;
#(
    parameter int width      = 8,
    parameter bit fixed_prio = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [width-1:0] d0,
    input  logic             d0_valid,
    output logic             d0_ready,
    input  logic [width-1:0] d1,
    input  logic             d1_valid,
    output logic             d1_ready,
    output logic [width-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output src_t             y_src
);

    src_t             ptr;
    logic             adv;
    logic             grant0;
    logic             grant1;
    logic             xfer;
    logic [width-1:0] mux_y;

    always_comb begin
        adv    = ~y_valid | y_ready;
        // d0 wins a tie in fixed mode, or when d1 was granted last.
        grant0 = d0_valid & (~d1_valid | fixed_prio | (ptr == SRC_D1));
        grant1 = d1_valid & ~grant0;
        // Nothing is accepted while reset is held.
        d0_ready = grant0 & adv & reset_n;
        d1_ready = grant1 & adv & reset_n;
        xfer     = d0_ready | d1_ready;
    end

    mux2 #(
        .width(width)
    ) u_mux (
        .d0(d0),
        .d1(d1),
        .s (grant1),
        .y (mux_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_src   <= SRC_D0;
            ptr     <= POINTER_RESET;
        end else if (xfer) begin
            y       <= mux_y;
            y_valid <= 1'b1;
            y_src   <= src_t'(grant1);
            if (!fixed_prio) begin
                ptr <= src_t'(grant1);
            end
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule
